main: RTL and testbench
=======================

# main

Registered vending-machine controller: holds a per-product stock table, processes one purchase or restock transaction per clock edge, and reports the outcome as a 7-bit error flag word. It is the top-level datapath/control block of the vending machine. It has no change/dispense outputs; downstream logic and benches infer success from an all-zero `error` and from the stock table.

## Interface
Parameters: none; all constants live in `main_pkg`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  0 idle, 1 purchase, 2 restock, 3 reserved (invalid)
- `customer_money`  in  7  money inserted, unsigned 0..127
- `supply_type`  in  3  product index; 0..5 valid, 6..7 invalid
- `customer_amount`  in  4  units requested in a purchase
- `amount_sypply_to_add`  in  4  units added in a restock (port name spelled exactly so)
- `error`  out  7  registered outcome flags of the last transaction

## Operation
- State: `stock[0:5]`, 4-bit each (0..15). Prices: type 0..5 = 5, 7, 10, 12, 15, 20.
- Error bits:
  - [0] insufficient money
  - [1] insufficient stock
  - [2] zero purchase amount
  - [3] restock overflow
  - [4] zero restock amount
  - [5] invalid mode
  - [6] invalid supply type
- Each rising edge with `rst`=0 evaluates the current inputs as one transaction. Inputs held for N edges give N transactions.
- Mode 0 (idle): `error` <= 0. Stock is unchanged.
- Mode 1 (purchase):
  - Invalid type: `error` = bit6 only. No other checks.
  - Otherwise cost = PRICE[type] × `customer_amount`, computed 9 bits wide (max 300). `customer_money` is zero-extended for the compare.
  - Set bit2 if amount = 0. Set bit1 if stock[type] < amount. Set bit0 if money < cost. All applicable bits are set together.
  - If no bit is set, stock[type] -= amount.
- Mode 2 (restock):
  - Invalid type: bit6 only.
  - Otherwise set bit4 if add = 0. Set bit3 if stock[type] + add > 15, with the sum taken 5 bits wide.
  - If no bit is set, stock[type] += add.
- Mode 3: `error` = bit5 only. Stock is unchanged.
- A failed transaction never modifies any stock entry. No wrap-around: stock is neither decremented below 0 nor incremented above 15.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge): `error` <= 0 and every stock entry <= 5. Reset overrides any transaction on the same edge.
- Reset asserted mid-sequence discards that edge's transaction. Pending state is lost.
- Latency is 1 cycle. `error` is updated on the edge that samples the inputs and holds until the next edge.
- Stock updates are visible to the transaction on the following edge.
- No handshake. Inputs must be stable around each rising edge.

## Structure
- `main_pkg` holds:
  - NUM_TYPES = 6, INIT_STOCK = 5, MAX_STOCK = 15
  - PRICE table
  - mode encodings
  - error bit index constants
- Sub-module `main_inventory`: 6×4-bit stock register file.
  - One combinational read port indexed by type.
  - One write port: type, new value, write enable.
  - Reset to INIT_STOCK.
- `main` holds the cost multiply, comparisons, flag assembly and the `error` register.
- Stock is observable hierarchically as `uut.inv.stock[i]`.

## Test plan
- Reset: assert `rst` for 2 edges -> `error`=0, all stock = 5.
- Purchase held: mode 1, money 20, type 0, amount 2, held for 3 edges -> `error` 0, 0, 7'h02; stock[0] 3, 1, 1.
- Insufficient money: mode 1, type 5, amount 1, money 19 -> 7'h01, stock[5]=5. Then money 20 -> 7'h00, stock[5]=4.
- Restock: mode 2, type 2, add 10 -> 7'h00, stock[2]=15. Then add 1 -> 7'h08, stock[2]=15. Then add 0 -> 7'h10.
- Invalid cases:
  - mode 1, type 6 -> 7'h40
  - mode 3 -> 7'h20
  - mode 1, type 1, amount 0, money 0 -> 7'h04
  - mode 0 -> 7'h00
- Combined and reset:
  - Empty stock[0] to 1 first, then mode 1, type 0, amount 3, money 5 -> 7'h03.
  - Assert `rst` on the same edge as a valid purchase -> `error`=0, stock[0]=5.

Source files
------------

// File: rtl/main_pkg.sv
// Shared constants, types and helpers for the vending-machine controller.
// Prices, mode encodings and error-flag positions live here so every file agrees on them.
package main_pkg;

   localparam int unsigned NUM_TYPES = 6;
   localparam int unsigned TYPE_W    = 3;
   localparam int unsigned STOCK_W   = 4;
   localparam int unsigned MONEY_W   = 7;
   localparam int unsigned AMT_W     = 4;
   localparam int unsigned PRICE_W   = 5;
   localparam int unsigned COST_W    = 9;
   localparam int unsigned ERR_W     = 7;

   localparam logic [STOCK_W-1:0] INIT_STOCK = 4'd5;
   localparam logic [STOCK_W-1:0] MAX_STOCK  = 4'd15;

   localparam logic [PRICE_W-1:0] PRICE [NUM_TYPES] = '{
      5'd5, 5'd7, 5'd10, 5'd12, 5'd15, 5'd20
   };

   typedef enum logic [1:0] {
      MODE_IDLE     = 2'd0,
      MODE_PURCHASE = 2'd1,
      MODE_RESTOCK  = 2'd2,
      MODE_RESERVED = 2'd3
   } mode_e;

   localparam int unsigned ERR_MONEY      = 0;
   localparam int unsigned ERR_STOCK      = 1;
   localparam int unsigned ERR_ZERO_BUY   = 2;
   localparam int unsigned ERR_OVERFLOW   = 3;
   localparam int unsigned ERR_ZERO_ADD   = 4;
   localparam int unsigned ERR_MODE       = 5;
   localparam int unsigned ERR_TYPE       = 6;

   typedef logic [ERR_W-1:0]   err_t;
   typedef logic [TYPE_W-1:0]  type_t;
   typedef logic [STOCK_W-1:0] stock_t;

   function automatic logic type_valid(input type_t t);
      return t < TYPE_W'(NUM_TYPES);
   endfunction

   // Out-of-range indices map to price 0; callers reject them via type_valid first.
   function automatic logic [PRICE_W-1:0] price_of(input type_t t);
      logic [PRICE_W-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_TYPES; i++) begin
         if (t == TYPE_W'(i)) p = PRICE[i];
      end
      return p;
   endfunction

   function automatic logic [COST_W-1:0] cost_of(input type_t t, input logic [AMT_W-1:0] amt);
      return COST_W'(price_of(t)) * COST_W'(amt);
   endfunction

endpackage

// File: rtl/main_inventory.sv
// Six-entry stock register file: one combinational read port, one write port.
// All entries return to INIT_STOCK on synchronous reset.
module main_inventory
   import main_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  type_t  rd_idx_i,
   output stock_t rd_data_o,
   input  logic   wr_en_i,
   input  type_t  wr_idx_i,
   input  stock_t wr_data_i
);

   stock_t stock [NUM_TYPES];

   always_comb begin
      rd_data_o = '0;
      for (int i = 0; i < NUM_TYPES; i++) begin
         if (rd_idx_i == TYPE_W'(i)) rd_data_o = stock[i];
      end
   end

   // NOTE: this file is built from flops, not a RAM macro, so every entry is reset
   // explicitly; a RAM array would have to be cleared by a sequencer instead.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TYPES; i++) stock[i] <= INIT_STOCK;
      end else begin
         for (int i = 0; i < NUM_TYPES; i++) begin
            if (wr_en_i && wr_idx_i == TYPE_W'(i)) stock[i] <= wr_data_i;
         end
      end
   end

endmodule

// File: rtl/main.sv
// Vending-machine controller: one purchase/restock transaction per clock edge,
// outcome reported one cycle later as a registered 7-bit error flag word.
module main
   import main_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic [MONEY_W-1:0] customer_money,
   input  logic [TYPE_W-1:0]  supply_type,
   input  logic [AMT_W-1:0]   customer_amount,
   input  logic [AMT_W-1:0]   amount_sypply_to_add,
   output logic [ERR_W-1:0]   error
);

   mode_e               mode_s;
   logic                type_ok;
   stock_t              rd_data;
   logic [COST_W-1:0]   cost;
   logic [STOCK_W:0]    restock_sum;
   err_t                error_d, error_q;
   logic                wr_en;
   stock_t              wr_data;

   assign mode_s      = mode_e'(mode);
   assign type_ok     = type_valid(supply_type);
   assign cost        = cost_of(supply_type, customer_amount);
   assign restock_sum = {1'b0, rd_data} + {1'b0, amount_sypply_to_add};

   main_inventory inv (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_i  (supply_type),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en),
      .wr_idx_i  (supply_type),
      .wr_data_i (wr_data)
   );

   // A stock write happens only when the transaction raised no flag at all.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      error_d = '0;
      wr_en   = 1'b0;
      wr_data = rd_data;
      case (mode_s)
         MODE_IDLE: begin
         end
         MODE_PURCHASE: begin
            if (!type_ok) begin
               error_d[ERR_TYPE] = 1'b1;
            end else begin
               error_d[ERR_ZERO_BUY] = (customer_amount == '0);
               error_d[ERR_STOCK]    = (rd_data < customer_amount);
               error_d[ERR_MONEY]    = ({2'b00, customer_money} < cost);
               wr_en   = (error_d == '0);
               wr_data = rd_data - customer_amount;
            end
         end
         MODE_RESTOCK: begin
            if (!type_ok) begin
               error_d[ERR_TYPE] = 1'b1;
            end else begin
               error_d[ERR_ZERO_ADD] = (amount_sypply_to_add == '0);
               error_d[ERR_OVERFLOW] = (restock_sum > {1'b0, MAX_STOCK});
               wr_en   = (error_d == '0);
               wr_data = restock_sum[STOCK_W-1:0];
            end
         end
         MODE_RESERVED: begin
            error_d[ERR_MODE] = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) error_q <= '0;
      else     error_q <= error_d;
   end

   assign error = error_q;

endmodule

// File: tb/tb_main.sv
// Self-checking bench for main: directed vector table, reset corner cases,
// and randomized transactions checked against a behavioural stock/price model.
module tb_main;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [6:0] customer_money;
   logic [2:0] supply_type;
   logic [3:0] customer_amount;
   logic [3:0] amount_sypply_to_add;
   logic [6:0] error;

   int checks = 0;
   int errors = 0;

   int price_m [6] = '{5, 7, 10, 12, 15, 20};
   int stock_m [6];

   main uut (
      .clk                  (clk),
      .rst                  (rst),
      .mode                 (mode),
      .customer_money       (customer_money),
      .supply_type          (supply_type),
      .customer_amount      (customer_amount),
      .amount_sypply_to_add (amount_sypply_to_add),
      .error                (error)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0] m;
      logic [6:0] money;
      logic [2:0] typ;
      logic [3:0] amt;
      logic [3:0] add;
      logic [6:0] exp_err;
      int         chk_idx;
      int         exp_stock;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Drive one transaction mid-cycle, let the edge sample it, then settle before checking.
   task automatic drive(input logic r, input logic [1:0] m, input logic [6:0] money,
                        input logic [2:0] t, input logic [3:0] amt, input logic [3:0] add);
      @(negedge clk);
      rst = r; mode = m; customer_money = money; supply_type = t;
      customer_amount = amt; amount_sypply_to_add = add;
      @(posedge clk);
      #1;
   endtask

   function automatic int get_stock(input int i);
      return int'(uut.inv.stock[i]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 6; i++) stock_m[i] = 5;
   endtask

   // Expected outcome from the transaction rules, using plain integer arithmetic.
   task automatic model_step(input int m, input int money, input int t, input int amt,
                             input int add, output int e);
      e = 0;
      if (m == 1 || m == 2) begin
         if (t > 5) begin
            e = 'h40;
         end else if (m == 1) begin
            if (amt == 0) e += 'h04;
            if (stock_m[t] < amt) e += 'h02;
            if (money < price_m[t] * amt) e += 'h01;
            if (e == 0) stock_m[t] -= amt;
         end else begin
            if (add == 0) e += 'h10;
            if (stock_m[t] + add > 15) e += 'h08;
            if (e == 0) stock_m[t] += add;
         end
      end else if (m == 3) begin
         e = 'h20;
      end
   endtask

   task automatic check_all_stock(input string name);
      for (int i = 0; i < 6; i++) check($sformatf("%s_stock%0d", name, i), get_stock(i), stock_m[i]);
   endtask

   initial begin
      int e;

      vecs[0]  = '{2'd1, 7'd20, 3'd0, 4'd2,  4'd0,  7'h00, 0, 3};
      vecs[1]  = '{2'd1, 7'd20, 3'd0, 4'd2,  4'd0,  7'h00, 0, 1};
      vecs[2]  = '{2'd1, 7'd20, 3'd0, 4'd2,  4'd0,  7'h02, 0, 1};
      vecs[3]  = '{2'd1, 7'd19, 3'd5, 4'd1,  4'd0,  7'h01, 5, 5};
      vecs[4]  = '{2'd1, 7'd20, 3'd5, 4'd1,  4'd0,  7'h00, 5, 4};
      vecs[5]  = '{2'd2, 7'd0,  3'd2, 4'd0,  4'd10, 7'h00, 2, 15};
      vecs[6]  = '{2'd2, 7'd0,  3'd2, 4'd0,  4'd1,  7'h08, 2, 15};
      vecs[7]  = '{2'd2, 7'd0,  3'd2, 4'd0,  4'd0,  7'h10, 2, 15};
      vecs[8]  = '{2'd1, 7'd50, 3'd6, 4'd1,  4'd0,  7'h40, 0, 1};
      vecs[9]  = '{2'd2, 7'd0,  3'd7, 4'd0,  4'd3,  7'h40, 0, 1};
      vecs[10] = '{2'd3, 7'd99, 3'd0, 4'd1,  4'd1,  7'h20, 0, 1};
      vecs[11] = '{2'd1, 7'd0,  3'd1, 4'd0,  4'd0,  7'h04, 1, 5};
      vecs[12] = '{2'd0, 7'd99, 3'd0, 4'd1,  4'd1,  7'h00, 0, 1};
      vecs[13] = '{2'd1, 7'd5,  3'd0, 4'd3,  4'd0,  7'h03, 0, 1};

      rst = 1'b1; mode = 2'd0; customer_money = '0; supply_type = '0;
      customer_amount = '0; amount_sypply_to_add = '0;

      drive(1'b1, 2'd1, 7'd20, 3'd0, 4'd1, 4'd0);
      drive(1'b1, 2'd1, 7'd20, 3'd0, 4'd1, 4'd0);
      model_reset();
      check("reset_error", int'(error), 0);
      check_all_stock("reset");

      for (int v = 0; v < 14; v++) begin
         drive(1'b0, vecs[v].m, vecs[v].money, vecs[v].typ, vecs[v].amt, vecs[v].add);
         check($sformatf("vec%0d_error", v), int'(error), int'(vecs[v].exp_err));
         check($sformatf("vec%0d_stock", v), get_stock(vecs[v].chk_idx), vecs[v].exp_stock);
      end

      // Reset on the same edge as a valid purchase: the purchase is discarded.
      drive(1'b1, 2'd1, 7'd100, 3'd0, 4'd1, 4'd0);
      model_reset();
      check("rst_with_buy_error", int'(error), 0);
      check_all_stock("rst_with_buy");

      // Exact-money purchase of a full shelf, then restock to exactly MAX.
      drive(1'b0, 2'd1, 7'd75, 3'd4, 4'd5, 4'd0);
      check("exact_money_error", int'(error), 0);
      check("exact_money_stock", get_stock(4), 0);
      drive(1'b0, 2'd1, 7'd127, 3'd4, 4'd1, 4'd0);
      check("empty_shelf_error", int'(error), 'h02);
      drive(1'b0, 2'd2, 7'd0, 3'd4, 4'd15, 4'd15);
      check("fill_to_max_error", int'(error), 0);
      check("fill_to_max_stock", get_stock(4), 15);
      drive(1'b1, 2'd0, 7'd0, 3'd0, 4'd0, 4'd0);
      model_reset();
      check_all_stock("pre_random");

      for (int n = 0; n < 400; n++) begin
         logic       r;
         logic [1:0] m;
         logic [6:0] money;
         logic [2:0] t;
         logic [3:0] amt;
         logic [3:0] add;
         r     = ($urandom_range(0, 39) == 0);
         m     = 2'($urandom_range(0, 3));
         money = 7'($urandom_range(0, 127));
         t     = 3'($urandom_range(0, 7));
         amt   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
         add   = 4'($urandom_range(0, 15));
         drive(r, m, money, t, amt, add);
         if (r) begin
            model_reset();
            e = 0;
         end else begin
            model_step(int'(m), int'(money), int'(t), int'(amt), int'(add), e);
         end
         check($sformatf("rand%0d_error", n), int'(error), e);
         check_all_stock($sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
